block_fetch_sequencer: RTL and testbench

- Sequences instruction fetch for one TRIPS block inside the I-tile.
- Accepts a block-fetch command from the G-tile and issues sequential 32-bit word reads to the I-cache.
- Streams returned words, tagged with instruction index, to isa_decoder.
- Pulses fetch_new_block so the decoder's auto LSID/EXIT_ID counters restart at each block boundary.

---
 rtl/block_fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_credit_counter.sv | 42 ++++
 rtl/block_fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_block_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_fetch_sequencer_pkg.sv
// Shared types and constants for the TRIPS block fetch sequencer.
package block_fetch_sequencer_pkg;

    localparam int CHUNK_INSTRS = 32;
    localparam int MAX_CHUNKS   = 4;
    localparam int INSTR_IDX_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ISSUE,
        DRAIN,
        DONE,
        FLUSH
    } fetch_state_e;

    // Bits needed to hold values 0..max_value inclusive.
    function automatic int count_width(input int max_value);
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/fetch_credit_counter.sv
// Saturating up/down counter tracking in-flight I-cache reads.
module fetch_credit_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             inc_ok;
    logic             dec_ok;

    // A decrement with nothing outstanding is a stray response and is dropped.
    always_comb begin
        inc_ok     = inc && (count_reg < CNT_W'(MAX_COUNT));
        dec_ok     = dec && (count_reg != '0);
        count_next = count_reg;
        if (inc_ok && !dec_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg >= CNT_W'(MAX_COUNT));

endmodule

// File: rtl/block_fetch_sequencer.sv
// Fetches one TRIPS block word-by-word from the I-cache and streams it to the decoder.
// Optional FETCH_PERF_CNT_EN adds a busy-cycle counter output.
module block_fetch_sequencer #(
    parameter int ADDR_W          = 32,
    parameter int CHUNK_INSTRS    = block_fetch_sequencer_pkg::CHUNK_INSTRS,
    parameter int MAX_CHUNKS      = block_fetch_sequencer_pkg::MAX_CHUNKS,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [2:0]        fetch_num_chunks,
    input  logic              flush,
    output logic              icache_req_valid,
    input  logic              icache_req_ready,
    output logic [ADDR_W-1:0] icache_req_addr,
    input  logic              icache_rsp_valid,
    input  logic [31:0]       icache_rsp_data,
    output logic              fetch_new_block,
    output logic              dec_instr_valid,
    output logic [31:0]       dec_raw_instr,
    output logic [block_fetch_sequencer_pkg::INSTR_IDX_W-1:0] dec_instr_idx,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       perf_fetch_cycles,
`endif
    output logic              fetch_busy,
    output logic              fetch_done
);

    import block_fetch_sequencer_pkg::*;

    localparam int TOTAL_MAX = CHUNK_INSTRS * MAX_CHUNKS;
    localparam int CNT_W     = count_width(TOTAL_MAX);
    localparam int OUT_W     = count_width(MAX_OUTSTANDING);

    fetch_state_e             state_reg;
    fetch_state_e             state_next;
    logic [ADDR_W-1:0]        base_reg;
    logic [CNT_W-1:0]         total_reg;
    logic [CNT_W-1:0]         issued_reg;
    logic [CNT_W-1:0]         issued_next;
    logic [CNT_W-1:0]         received_reg;
    logic [CNT_W-1:0]         total_cmd;
    logic [2:0]               chunks_sat;
    logic                     dec_valid_reg;
    logic [31:0]              dec_data_reg;
    logic [INSTR_IDX_W-1:0]   dec_idx_reg;
    logic [OUT_W-1:0]         outstanding;
    logic                     out_full;
    logic                     cmd_accept;
    logic                     req_accept;
    logic                     rsp_accept;
    logic                     rsp_deliver;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^fetch_addr[1:0];

    assign chunks_sat = (fetch_num_chunks > 3'(MAX_CHUNKS)) ? 3'(MAX_CHUNKS) : fetch_num_chunks;
    assign total_cmd  = CNT_W'(chunks_sat) * CNT_W'(CHUNK_INSTRS);

    assign fetch_req_ready  = (state_reg == IDLE);
    assign fetch_busy       = (state_reg != IDLE);
    assign fetch_new_block  = (state_reg == START);
    assign fetch_done       = (state_reg == DONE);
    assign icache_req_valid = (state_reg == ISSUE) && (issued_reg < total_reg) && !out_full;
    assign icache_req_addr  = base_reg + {{(ADDR_W-CNT_W-2){1'b0}}, issued_reg, 2'b00};

    assign cmd_accept  = fetch_req_valid && fetch_req_ready;
    assign req_accept  = icache_req_valid && icache_req_ready;
    // Responses still retire credits while flushing; in IDLE they are stray and ignored.
    assign rsp_accept  = icache_rsp_valid && (state_reg != IDLE);
    assign rsp_deliver = icache_rsp_valid && !flush &&
                         ((state_reg == ISSUE) || (state_reg == DRAIN));
    assign issued_next = issued_reg + CNT_W'(req_accept);

    fetch_credit_counter #(
        .MAX_COUNT (MAX_OUTSTANDING),
        .CNT_W     (OUT_W)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (req_accept),
        .dec   (rsp_accept),
        .count (outstanding),
        .full  (out_full)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cmd_accept) state_next = START;
            START:   state_next = (total_reg == '0) ? DONE : ISSUE;
            ISSUE:   if (issued_next == total_reg) state_next = DRAIN;
            DRAIN:   if (received_reg == total_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            FLUSH:   if (outstanding == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush overrides every transition out of an active state, including DRAIN->DONE.
        if (flush && (state_reg != IDLE) && (state_reg != FLUSH)) begin
            state_next = FLUSH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            total_reg     <= '0;
            issued_reg    <= '0;
            received_reg  <= '0;
            dec_valid_reg <= 1'b0;
            dec_data_reg  <= '0;
            dec_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            dec_valid_reg <= rsp_deliver;
            if (cmd_accept) begin
                base_reg     <= {fetch_addr[ADDR_W-1:2], 2'b00};
                total_reg    <= total_cmd;
                issued_reg   <= '0;
                received_reg <= '0;
            end else begin
                issued_reg <= issued_next;
                if (rsp_deliver) begin
                    dec_data_reg <= icache_rsp_data;
                    dec_idx_reg  <= received_reg[INSTR_IDX_W-1:0];
                    received_reg <= received_reg + CNT_W'(1);
                end
            end
        end
    end

    assign dec_instr_valid = dec_valid_reg;
    assign dec_raw_instr   = dec_data_reg;
    assign dec_instr_idx   = dec_idx_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_reg <= '0;
        end else if (cmd_accept) begin
            perf_reg <= '0;
        end else if (fetch_busy && (perf_reg != 16'hFFFF)) begin
            perf_reg <= perf_reg + 16'd1;
        end
    end

    assign perf_fetch_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_block_fetch_sequencer.sv
// Self-checking bench for block_fetch_sequencer: table of fetch commands plus flush and reset sequences.
`timescale 1ns/1ps
module tb_block_fetch_sequencer;

    localparam logic [31:0] DATA_KEY = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req_valid;
    logic        fetch_req_ready;
    logic [31:0] fetch_addr;
    logic [2:0]  fetch_num_chunks;
    logic        flush;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_data;
    logic        fetch_new_block;
    logic        dec_instr_valid;
    logic [31:0] dec_raw_instr;
    logic [6:0]  dec_instr_idx;
    logic        fetch_busy;
    logic        fetch_done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cycles;
`endif

    always #5 clk = ~clk;

    block_fetch_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_req_valid  (fetch_req_valid),
        .fetch_req_ready  (fetch_req_ready),
        .fetch_addr       (fetch_addr),
        .fetch_num_chunks (fetch_num_chunks),
        .flush            (flush),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .fetch_new_block  (fetch_new_block),
        .dec_instr_valid  (dec_instr_valid),
        .dec_raw_instr    (dec_raw_instr),
        .dec_instr_idx    (dec_instr_idx),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cycles(perf_fetch_cycles),
`endif
        .fetch_busy       (fetch_busy),
        .fetch_done       (fetch_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  chunks;
        bit          toggle_ready;
        int          delay;
        int          exp_reqs;
        logic [31:0] exp_base;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs[5];
    rsp_t        rsp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] base_exp;
    bit          toggle_ready;
    int          rsp_delay;
    int          nb_cnt, done_cnt, busy_cnt, req_cnt, dec_cnt;
    int          idx_err, data_err, addr_err, outst, max_out;
    int          nb_cyc, done_cyc, last_dec_cyc, last_idx;
    int          flush_cyc, dec_after_flush, req_after_flush;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        nb_cnt = 0; done_cnt = 0; busy_cnt = 0; req_cnt = 0; dec_cnt = 0;
        idx_err = 0; data_err = 0; addr_err = 0; outst = 0; max_out = 0;
        nb_cyc = 0; done_cyc = 0; last_dec_cyc = 0; last_idx = -1;
        flush_cyc = 32'h7FFF_FFFF; dec_after_flush = 0; req_after_flush = 0;
    endtask

    // One clock cycle: observe DUT at the falling edge, then drive the cache model.
    task automatic tick();
        rsp_t r;
        @(negedge clk);
        cyc++;
        if (fetch_new_block) begin nb_cnt++; nb_cyc = cyc; end
        if (fetch_done) begin done_cnt++; done_cyc = cyc; end
        if (fetch_busy) busy_cnt++;
        if (dec_instr_valid) begin
            if (dec_instr_idx != 7'(dec_cnt)) idx_err++;
            if (dec_raw_instr != ((base_exp + 32'(4 * dec_cnt)) ^ DATA_KEY)) data_err++;
            if (cyc > flush_cyc) dec_after_flush++;
            last_idx = int'(dec_instr_idx);
            last_dec_cyc = cyc;
            dec_cnt++;
        end
        icache_req_ready = toggle_ready ? ((cyc % 2) == 1) : 1'b1;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            r = rsp_q.pop_front();
            icache_rsp_valid = 1'b1;
            icache_rsp_data  = r.data;
            outst--;
        end else begin
            icache_rsp_valid = 1'b0;
        end
        if (icache_req_valid && icache_req_ready) begin
            if (icache_req_addr != base_exp + 32'(4 * req_cnt)) addr_err++;
            if (cyc > flush_cyc) req_after_flush++;
            r.due  = cyc + rsp_delay;
            r.data = icache_req_addr ^ DATA_KEY;
            rsp_q.push_back(r);
            req_cnt++;
            outst++;
        end
        if (outst > max_out) max_out = outst;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int n;
        clear_stats();
        base_exp     = v.exp_base;
        toggle_ready = v.toggle_ready;
        rsp_delay    = v.delay;
        chk($sformatf("v%0d_ready_idle", id), fetch_req_ready, 1);
        fetch_req_valid  = 1'b1;
        fetch_addr       = v.addr;
        fetch_num_chunks = v.chunks;
        tick();
        // A command held valid during the fetch must not be taken.
        fetch_addr       = 32'hFFFF_F000;
        fetch_num_chunks = 3'd1;
        n = 0;
        while (fetch_busy && n < 4000) begin
            tick();
            n++;
        end
        fetch_req_valid = 1'b0;
        chk($sformatf("v%0d_timeout", id), fetch_busy, 0);
        chk($sformatf("v%0d_new_block", id), nb_cnt, 1);
        chk($sformatf("v%0d_done_pulses", id), done_cnt, 1);
        chk($sformatf("v%0d_requests", id), req_cnt, v.exp_reqs);
        chk($sformatf("v%0d_delivered", id), dec_cnt, v.exp_reqs);
        chk($sformatf("v%0d_idx_errs", id), idx_err, 0);
        chk($sformatf("v%0d_data_errs", id), data_err, 0);
        chk($sformatf("v%0d_addr_errs", id), addr_err, 0);
        chk($sformatf("v%0d_max_out_le_4", id), max_out <= 4, 1);
        if (v.exp_reqs > 0) begin
            chk($sformatf("v%0d_last_idx", id), last_idx, v.exp_reqs - 1);
            chk($sformatf("v%0d_done_gap", id), done_cyc - last_dec_cyc, 1);
        end else begin
            chk($sformatf("v%0d_nb_to_done", id), done_cyc - nb_cyc, 1);
        end
`ifdef FETCH_PERF_CNT_EN
        chk($sformatf("v%0d_perf", id), perf_fetch_cycles, busy_cnt);
`endif
        $display("vec %0d addr=%h chunks=%0d reqs=%0d delivered=%0d max_out=%0d done=%0d busy=%0d",
                 id, v.addr, v.chunks, req_cnt, dec_cnt, max_out, done_cnt, busy_cnt);
    endtask

    initial begin
        int n;
        int dec_before;
        vecs[0] = '{32'h0000_1000, 3'd1, 1'b0, 2, 32,  32'h0000_1000};
        vecs[1] = '{32'h0000_2000, 3'd4, 1'b1, 5, 128, 32'h0000_2000};
        vecs[2] = '{32'h0000_3000, 3'd0, 1'b0, 2, 0,   32'h0000_3000};
        vecs[3] = '{32'h0000_4003, 3'd7, 1'b0, 3, 128, 32'h0000_4000};
        vecs[4] = '{32'h0000_5002, 3'd2, 1'b1, 1, 64,  32'h0000_5000};

        rst = 1'b1; fetch_req_valid = 1'b0; fetch_addr = '0; fetch_num_chunks = '0;
        flush = 1'b0; icache_req_ready = 1'b0; icache_rsp_valid = 1'b0; icache_rsp_data = '0;
        toggle_ready = 1'b0; rsp_delay = 2; base_exp = '0;
        clear_stats();
        #1;
        chk("rst_req_ready", fetch_req_ready, 1);
        chk("rst_req_valid", icache_req_valid, 0);
        chk("rst_req_addr", icache_req_addr, 0);
        chk("rst_busy", fetch_busy, 0);
        chk("rst_dec_valid", dec_instr_valid, 0);
        chk("rst_done", fetch_done, 0);
        chk("rst_new_block", fetch_new_block, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf", perf_fetch_cycles, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Flush with 10 requests issued and 3 responses pending.
        clear_stats();
        base_exp = 32'h0000_6000; toggle_ready = 1'b0; rsp_delay = 3;
        fetch_req_valid = 1'b1; fetch_addr = 32'h0000_6000; fetch_num_chunks = 3'd2;
        tick();
        fetch_req_valid = 1'b0;
        n = 0;
        while (req_cnt < 10 && n < 200) begin tick(); n++; end
        chk("flush_pre_outstanding", outst, 3);
        flush = 1'b1;
        flush_cyc = cyc;
        tick();
        flush = 1'b0;
        n = 0;
        while (fetch_busy && n < 200) begin tick(); n++; end
        chk("flush_timeout", fetch_busy, 0);
        chk("flush_dec_after", dec_after_flush, 0);
        chk("flush_req_after", req_after_flush, 0);
        chk("flush_requests", req_cnt, 10);
        chk("flush_no_done", done_cnt, 0);
        chk("flush_rsp_drained", rsp_q.size(), 0);
        chk("flush_ready", fetch_req_ready, 1);
        $display("flush seq: reqs=%0d delivered=%0d done=%0d", req_cnt, dec_cnt, done_cnt);
        run_vec(5, vecs[0]);

        // Asynchronous reset in the middle of ISSUE.
        clear_stats();
        base_exp = 32'h0000_7000; toggle_ready = 1'b0; rsp_delay = 2;
        fetch_req_valid = 1'b1; fetch_addr = 32'h0000_7000; fetch_num_chunks = 3'd1;
        tick();
        fetch_req_valid = 1'b0;
        n = 0;
        while (req_cnt < 5 && n < 200) begin tick(); n++; end
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", fetch_req_ready, 1);
        chk("arst_req_valid", icache_req_valid, 0);
        chk("arst_busy", fetch_busy, 0);
        chk("arst_dec_valid", dec_instr_valid, 0);
        chk("arst_req_addr", icache_req_addr, 0);
        tick();
        rst = 1'b0;
        dec_before = dec_cnt;
        repeat (10) tick();
        chk("arst_no_dec_after", dec_cnt - dec_before, 0);
        chk("arst_idle_busy", fetch_busy, 0);
        chk("arst_ready_after", fetch_req_ready, 1);
        $display("reset seq: reqs_before=%0d dec_after=%0d", req_cnt, dec_cnt - dec_before);
        run_vec(6, vecs[2]);
        run_vec(7, vecs[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
